ctrl_bm_gen2: RTL and testbench

//  Second-generation Bin_Manager sequencer. Drives the flow: read info -> load bin -> run core ->
//  (find bkt lvl -> bkt across bin) -> update bin, until the result is global SAT or global UNSAT.

---
 rtl/bm_pkg.sv | 41 ++++
 rtl/bm_phase_timer.sv | 40 ++++
 rtl/ctrl_bm_gen2.sv | 213 +++++++++++++++++++++
 tb/tb_ctrl_bm_gen2.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// Shared types and constants for the second-generation bin-manager sequencer.
//   bm_state_e : sequencer states
//   ERR_*      : error codes reported on err_code_o
//   bin_id_t / lvl_t : default-width bin index and decision-level types
package bm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_INFO,
    ST_LOAD,
    ST_CORE,
    ST_FIND,
    ST_BKT,
    ST_UPDATE,
    ST_DONE_SAT,
    ST_DONE_UNSAT,
    ST_DONE_ERR
  } bm_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_BAD_BKT = 2'd3;

  localparam int DEF_WIDTH_BIN_ID = 10;
  localparam int DEF_WIDTH_LVL    = 16;

  typedef logic [DEF_WIDTH_BIN_ID-1:0] bin_id_t;
  typedef logic [DEF_WIDTH_LVL-1:0]    lvl_t;

  // Busy states wait on an engine handshake; they are watchdog- and abort-sensitive.
  function automatic logic is_busy(input bm_state_e s);
    return (s == ST_RD_INFO) || (s == ST_LOAD) || (s == ST_CORE) ||
           (s == ST_FIND) || (s == ST_BKT) || (s == ST_UPDATE);
  endfunction

  function automatic logic is_done(input bm_state_e s);
    return (s == ST_DONE_SAT) || (s == ST_DONE_UNSAT) || (s == ST_DONE_ERR);
  endfunction

endpackage

// File: rtl/bm_phase_timer.sv
// Per-phase timer for the bin-manager sequencer.
//   clk, rst      : clock, async active-low reset
//   enter_i       : a new state begins on this edge
//   busy_i        : current state is a busy (handshake) state
//   phase_done_i  : the engine of the current state answered this cycle
//   limit_i       : cycle limit per phase; 0 disables the watchdog
//   first_o       : high on the first cycle of a newly entered state
//   expired_o     : limit reached without an answer this cycle
module bm_phase_timer #(
  parameter int WIDTH_TMO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_i,
  input  logic                 busy_i,
  input  logic                 phase_done_i,
  input  logic [WIDTH_TMO-1:0] limit_i,
  output logic                 first_o,
  output logic                 expired_o
);

  logic [WIDTH_TMO-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      first_o <= 1'b0;
    end else begin
      first_o <= enter_i;
      if (enter_i)
        cnt <= '0;
      else if (busy_i)
        cnt <= cnt + 1'b1;
    end
  end

  // The counter reads 0 on the first cycle of a phase, so limit-1 is the last allowed cycle.
  assign expired_o = busy_i && (limit_i != '0) && (cnt == limit_i - 1'b1) && !phase_done_i;

endmodule

// File: rtl/ctrl_bm_gen2.sv
// Second-generation bin-manager sequencer:
// read info -> load bin -> run core -> (find bkt lvl -> bkt across bin) -> update bin,
// until global SAT, global UNSAT or an error (timeout, abort, bad backtrack bin).
// Ports:
//   clk, rst (async, active low); start_bm_i, abort_i, timeout_cycles_i
//   done_bm_o, global_sat_o, global_unsat_o, error_o, err_code_o
//   cur_bin_num_o, cur_lvl_o, request_bin_num_o, update_fwd_o, stat_bins_o, stat_bkts_o
//   start_*_o / done_*_i handshakes to the rdinfo, load, core, find, bkt and update engines
//
//  state          | meaning
//  ST_IDLE        | waiting for start_bm_i after reset
//  ST_RD_INFO     | read-info engine running, nb_all sampled on completion
//  ST_LOAD        | loading cur_bin
//  ST_CORE        | core solving the loaded bin
//  ST_FIND        | searching backtrack level/bin
//  ST_BKT         | backtracking across bins
//  ST_UPDATE      | updating bin (forward when core said sat)
//  ST_DONE_SAT    | finished, global SAT
//  ST_DONE_UNSAT  | finished, global UNSAT
//  ST_DONE_ERR    | finished with err_code_o
module ctrl_bm_gen2 #(
  parameter int WIDTH_BIN_ID  = 10,
  parameter int WIDTH_CLAUSES = 16,
  parameter int WIDTH_LVL     = 16,
  parameter int WIDTH_TMO     = 16,
  parameter int WIDTH_STAT    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_bm_i,
  input  logic                     abort_i,
  input  logic [WIDTH_TMO-1:0]     timeout_cycles_i,
  output logic                     done_bm_o,
  output logic                     global_sat_o,
  output logic                     global_unsat_o,
  output logic                     error_o,
  output logic [1:0]               err_code_o,
  output logic [WIDTH_BIN_ID-1:0]  cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]     cur_lvl_o,
  output logic                     start_rdinfo_o,
  input  logic                     done_rdinfo_i,
  input  logic [WIDTH_CLAUSES-1:0] nb_all_i,
  output logic                     start_load_o,
  input  logic                     done_load_i,
  output logic [WIDTH_BIN_ID-1:0]  request_bin_num_o,
  output logic                     start_core_o,
  input  logic                     done_core_i,
  input  logic                     local_sat_i,
  input  logic [WIDTH_LVL-1:0]     cur_lvl_from_core_i,
  output logic                     start_find_o,
  input  logic                     done_find_i,
  input  logic [WIDTH_LVL-1:0]     bkt_lvl_from_find_i,
  input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_from_find_i,
  output logic                     start_bkt_across_bin_o,
  input  logic                     done_bkt_across_bin_i,
  output logic                     start_update_o,
  input  logic                     done_update_i,
  output logic                     update_fwd_o,
  output logic [WIDTH_STAT-1:0]    stat_bins_o,
  output logic [WIDTH_STAT-1:0]    stat_bkts_o
);
  import bm_pkg::*;

  localparam int WCMP = (WIDTH_BIN_ID > WIDTH_CLAUSES) ? WIDTH_BIN_ID : WIDTH_CLAUSES;
  localparam logic [WIDTH_BIN_ID-1:0] BIN_FIRST = {{(WIDTH_BIN_ID-1){1'b0}}, 1'b1};

  bm_state_e                state_q, state_d;
  logic [1:0]               err_next;
  logic [WIDTH_CLAUSES-1:0] nb_all;
  logic                     lsat;
  logic [WIDTH_BIN_ID-1:0]  cur_bin;
  logic                     busy, phase_done, acc, start_acc, bkt_ok, last_bin;
  logic                     first, expired;

  assign busy      = is_busy(state_q);
  assign start_acc = start_bm_i && ((state_q == ST_IDLE) || is_done(state_q));
  assign acc       = phase_done && !abort_i;
  assign bkt_ok    = (bkt_bin_from_find_i != '0) && (bkt_bin_from_find_i <= cur_bin);
  assign last_bin  = (WCMP'(cur_bin) == WCMP'(nb_all));

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_RD_INFO: phase_done = done_rdinfo_i;
      ST_LOAD:    phase_done = done_load_i;
      ST_CORE:    phase_done = done_core_i;
      ST_FIND:    phase_done = done_find_i;
      ST_BKT:     phase_done = done_bkt_across_bin_i;
      ST_UPDATE:  phase_done = done_update_i;
      default:    phase_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    err_next = ERR_NONE;
    case (state_q)
      ST_IDLE:    if (start_bm_i) state_d = ST_RD_INFO;
      ST_RD_INFO: if (done_rdinfo_i) state_d = (nb_all_i == '0) ? ST_DONE_SAT : ST_LOAD;
      ST_LOAD:    if (done_load_i) state_d = ST_CORE;
      ST_CORE:
        if (done_core_i) begin
          if (local_sat_i && last_bin) state_d = ST_DONE_SAT;
          else if (local_sat_i)        state_d = ST_UPDATE;
          else                         state_d = ST_FIND;
        end
      ST_FIND:
        if (done_find_i) begin
          if (bkt_bin_from_find_i == '0) begin
            state_d = ST_DONE_UNSAT;
          end else if (!bkt_ok) begin
            state_d  = ST_DONE_ERR;
            err_next = ERR_BAD_BKT;
          end else begin
            state_d = ST_BKT;
          end
        end
      ST_BKT:     if (done_bkt_across_bin_i) state_d = ST_UPDATE;
      ST_UPDATE:  if (done_update_i) state_d = ST_LOAD;
      default:    if (start_bm_i) state_d = ST_RD_INFO;
    endcase
    // Abort outranks both a same-cycle done and the watchdog.
    if (busy && abort_i) begin
      state_d  = ST_DONE_ERR;
      err_next = ERR_ABORT;
    end else if (expired) begin
      state_d  = ST_DONE_ERR;
      err_next = ERR_TIMEOUT;
    end
  end

  bm_phase_timer #(.WIDTH_TMO(WIDTH_TMO)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .enter_i      (state_d != state_q),
    .busy_i       (busy),
    .phase_done_i (phase_done),
    .limit_i      (timeout_cycles_i),
    .first_o      (first),
    .expired_o    (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      nb_all         <= '0;
      lsat           <= 1'b0;
      cur_bin        <= BIN_FIRST;
      cur_lvl_o      <= '0;
      stat_bins_o    <= '0;
      stat_bkts_o    <= '0;
      done_bm_o      <= 1'b0;
      global_sat_o   <= 1'b0;
      global_unsat_o <= 1'b0;
      error_o        <= 1'b0;
      err_code_o     <= ERR_NONE;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        cur_bin        <= BIN_FIRST;
        cur_lvl_o      <= '0;
        stat_bins_o    <= '0;
        stat_bkts_o    <= '0;
        done_bm_o      <= 1'b0;
        global_sat_o   <= 1'b0;
        global_unsat_o <= 1'b0;
        error_o        <= 1'b0;
        err_code_o     <= ERR_NONE;
      end else begin
        case (state_q)
          ST_RD_INFO: if (acc) nb_all <= nb_all_i;
          ST_CORE:
            if (acc) begin
              lsat <= local_sat_i;
              if (local_sat_i) cur_lvl_o <= cur_lvl_from_core_i;
            end
          ST_FIND:
            if (acc && bkt_ok) begin
              cur_bin   <= bkt_bin_from_find_i;
              cur_lvl_o <= bkt_lvl_from_find_i;
              if (stat_bkts_o != '1) stat_bkts_o <= stat_bkts_o + 1'b1;
            end
          ST_UPDATE:
            if (acc && lsat) begin
              cur_bin <= cur_bin + 1'b1;
              if (stat_bins_o != '1) stat_bins_o <= stat_bins_o + 1'b1;
            end
          default: ;
        endcase
        if ((state_d != state_q) && is_done(state_d)) begin
          done_bm_o      <= 1'b1;
          global_sat_o   <= (state_d == ST_DONE_SAT);
          global_unsat_o <= (state_d == ST_DONE_UNSAT);
          error_o        <= (state_d == ST_DONE_ERR);
          err_code_o     <= err_next;
        end
      end
    end
  end

  // Start pulses: one cycle, on the first cycle of the matching state only.
  assign start_rdinfo_o         = first && (state_q == ST_RD_INFO);
  assign start_load_o           = first && (state_q == ST_LOAD);
  assign start_core_o           = first && (state_q == ST_CORE);
  assign start_find_o           = first && (state_q == ST_FIND);
  assign start_bkt_across_bin_o = first && (state_q == ST_BKT);
  assign start_update_o         = first && (state_q == ST_UPDATE);

  assign cur_bin_num_o     = cur_bin;
  assign request_bin_num_o = cur_bin;
  assign update_fwd_o      = lsat && (state_q == ST_UPDATE);

endmodule

// File: tb/tb_ctrl_bm_gen2.sv
module tb_ctrl_bm_gen2;

  localparam int E_RD = 0, E_LD = 1, E_CO = 2, E_FI = 3, E_BK = 4, E_UP = 5, E_ST = 6;

  typedef struct {
    int          eng;
    logic [15:0] nb;
    logic        sat;
    logic [15:0] lvl;
    logic [9:0]  bbin;
    logic [9:0]  e_bin;
    logic [15:0] e_lvl;
    logic [31:0] e_sb;
    logic [31:0] e_sk;
    logic [3:0]  e_flags;
    logic [1:0]  e_code;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_bm_i = 0, abort_i = 0;
  logic [15:0] timeout_cycles_i = '0;
  logic done_bm_o, global_sat_o, global_unsat_o, error_o;
  logic [1:0] err_code_o;
  logic [9:0] cur_bin_num_o, request_bin_num_o;
  logic [15:0] cur_lvl_o;
  logic start_rdinfo_o, start_load_o, start_core_o, start_find_o, start_bkt_across_bin_o, start_update_o;
  logic done_rdinfo_i = 0, done_load_i = 0, done_core_i = 0, done_find_i = 0;
  logic done_bkt_across_bin_i = 0, done_update_i = 0;
  logic [15:0] nb_all_i = '0;
  logic local_sat_i = 0;
  logic [15:0] cur_lvl_from_core_i = '0, bkt_lvl_from_find_i = '0;
  logic [9:0] bkt_bin_from_find_i = '0;
  logic update_fwd_o;
  logic [31:0] stat_bins_o, stat_bkts_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start[6];

  always #5 clk = ~clk;

  ctrl_bm_gen2 dut (
    .clk(clk), .rst(rst), .start_bm_i(start_bm_i), .abort_i(abort_i),
    .timeout_cycles_i(timeout_cycles_i),
    .done_bm_o(done_bm_o), .global_sat_o(global_sat_o), .global_unsat_o(global_unsat_o),
    .error_o(error_o), .err_code_o(err_code_o),
    .cur_bin_num_o(cur_bin_num_o), .cur_lvl_o(cur_lvl_o),
    .start_rdinfo_o(start_rdinfo_o), .done_rdinfo_i(done_rdinfo_i), .nb_all_i(nb_all_i),
    .start_load_o(start_load_o), .done_load_i(done_load_i), .request_bin_num_o(request_bin_num_o),
    .start_core_o(start_core_o), .done_core_i(done_core_i), .local_sat_i(local_sat_i),
    .cur_lvl_from_core_i(cur_lvl_from_core_i),
    .start_find_o(start_find_o), .done_find_i(done_find_i),
    .bkt_lvl_from_find_i(bkt_lvl_from_find_i), .bkt_bin_from_find_i(bkt_bin_from_find_i),
    .start_bkt_across_bin_o(start_bkt_across_bin_o), .done_bkt_across_bin_i(done_bkt_across_bin_i),
    .start_update_o(start_update_o), .done_update_i(done_update_i),
    .update_fwd_o(update_fwd_o), .stat_bins_o(stat_bins_o), .stat_bkts_o(stat_bkts_o)
  );

  function automatic logic [5:0] start_vec();
    return {start_update_o, start_bkt_across_bin_o, start_find_o,
            start_core_o, start_load_o, start_rdinfo_o};
  endfunction

  always @(posedge clk) begin
    for (int e = 0; e < 6; e++)
      if (start_vec() & (6'd1 << e)) n_start[e]++;
  end

  function automatic int start_total();
    int t = 0;
    for (int e = 0; e < 6; e++) t += n_start[e];
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic step_t mk(input int eng, input int nb, input logic sat, input int lvl,
                               input int bbin, input int ebin, input int elvl, input int esb,
                               input int esk, input logic [3:0] ef, input logic [1:0] ec);
    step_t s;
    s.eng = eng; s.nb = 16'(nb); s.sat = sat; s.lvl = 16'(lvl); s.bbin = 10'(bbin);
    s.e_bin = 10'(ebin); s.e_lvl = 16'(elvl); s.e_sb = 32'(esb); s.e_sk = 32'(esk);
    s.e_flags = ef; s.e_code = ec;
    return s;
  endfunction

  task automatic check_outs(input step_t s, input string tag);
    check({tag, " flags"}, 64'({done_bm_o, global_sat_o, global_unsat_o, error_o}), 64'(s.e_flags));
    check({tag, " err_code"}, 64'(err_code_o), 64'(s.e_code));
    check({tag, " cur_bin"}, 64'(cur_bin_num_o), 64'(s.e_bin));
    check({tag, " cur_lvl"}, 64'(cur_lvl_o), 64'(s.e_lvl));
    check({tag, " stat_bins"}, 64'(stat_bins_o), 64'(s.e_sb));
    check({tag, " stat_bkts"}, 64'(stat_bkts_o), 64'(s.e_sk));
  endtask

  // Waits (bounded) for the engine start, answers in the same cycle, checks outputs after the edge.
  task automatic respond(input step_t s, input string tag);
    int k;
    if (s.eng == E_ST) begin
      start_bm_i = 1'b1;
      @(negedge clk);
      start_bm_i = 1'b0;
    end else begin
      k = 0;
      while (start_vec() == 6'd0 && k < 30) begin
        @(negedge clk);
        k++;
      end
      check({tag, " start_kind"}, 64'(start_vec()), 64'(6'd1 << s.eng));
      if (s.eng == E_LD) check({tag, " request_bin"}, 64'(request_bin_num_o), 64'(s.e_bin));
      if (s.eng == E_UP) check({tag, " update_fwd"}, 64'(update_fwd_o), 64'(s.sat));
      case (s.eng)
        E_RD: begin done_rdinfo_i = 1'b1; nb_all_i = s.nb; end
        E_LD: done_load_i = 1'b1;
        E_CO: begin done_core_i = 1'b1; local_sat_i = s.sat; cur_lvl_from_core_i = s.lvl; end
        E_FI: begin done_find_i = 1'b1; bkt_bin_from_find_i = s.bbin; bkt_lvl_from_find_i = s.lvl; end
        E_BK: done_bkt_across_bin_i = 1'b1;
        default: done_update_i = 1'b1;
      endcase
      @(negedge clk);
      {done_rdinfo_i, done_load_i, done_core_i, done_find_i, done_bkt_across_bin_i, done_update_i} = '0;
    end
    check_outs(s, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " flags"}, 64'({done_bm_o, global_sat_o, global_unsat_o, error_o, err_code_o}), 64'd0);
    check({tag, " starts"}, 64'({start_vec(), update_fwd_o}), 64'd0);
    check({tag, " bins"}, 64'({cur_bin_num_o, request_bin_num_o}), 64'({10'd1, 10'd1}));
    check({tag, " lvl_stats"}, 64'(cur_lvl_o) | 64'(stat_bins_o) | 64'(stat_bkts_o), 64'd0);
  endtask

  step_t tbl[$];
  int    s1_end;

  initial begin
    int snap[6];
    int tot, k;
    step_t z;

    // Scenario 1: nb_all=3, core sat on every bin.
    tbl.push_back(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_RD, 3, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 2, 0, 1, 2, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 2, 2, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 2, 2, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 3, 0, 2, 3, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 3, 3, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 3, 3, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 4, 0, 3, 4, 2, 0, 4'b1100, 2'd0));
    s1_end = tbl.size() - 1;
    // Scenario 2: restart from DONE_SAT, backtrack at bin 3 to bin 2, then UNSAT.
    tbl.push_back(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_RD, 4, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 1, 0, 1, 1, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 2, 1, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 2, 1, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 2, 0, 2, 2, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 0, 9, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_FI, 0, 0, 5, 2, 2, 5, 2, 1, 4'b0000, 2'd0));
    tbl.push_back(mk(E_BK, 0, 0, 0, 0, 2, 5, 2, 1, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 0, 0, 0, 2, 5, 2, 1, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 2, 5, 2, 1, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 0, 7, 0, 2, 5, 2, 1, 4'b0000, 2'd0));
    tbl.push_back(mk(E_FI, 0, 0, 3, 0, 2, 5, 2, 1, 4'b1010, 2'd0));
    // Scenario 3: find returns bin 7 at cur_bin 3 -> bad backtrack error.
    tbl.push_back(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_RD, 5, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 1, 0, 1, 1, 0, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 2, 1, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 2, 1, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 1, 2, 0, 2, 2, 1, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_UP, 0, 1, 0, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_LD, 0, 0, 0, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_CO, 0, 0, 4, 0, 3, 2, 2, 0, 4'b0000, 2'd0));
    tbl.push_back(mk(E_FI, 0, 0, 1, 7, 3, 2, 2, 0, 4'b1001, 2'd3));

    for (int e = 0; e < 6; e++) n_start[e] = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 6; e++) snap[e] = n_start[e];
    for (int i = 0; i < tbl.size(); i++) begin
      respond(tbl[i], $sformatf("step%0d", i));
      if (tbl[i].e_flags[3]) begin
        tot = start_total();
        repeat (10) @(negedge clk);
        check($sformatf("step%0d quiet_after_done", i), 64'(start_total() - tot), 64'd0);
      end
      if (i == s1_end) begin
        check("s1 rdinfo_starts", 64'(n_start[E_RD] - snap[E_RD]), 64'd1);
        check("s1 load_starts",   64'(n_start[E_LD] - snap[E_LD]), 64'd3);
        check("s1 core_starts",   64'(n_start[E_CO] - snap[E_CO]), 64'd3);
        check("s1 update_starts", 64'(n_start[E_UP] - snap[E_UP]), 64'd2);
        check("s1 find_bkt_starts", 64'(n_start[E_FI] + n_start[E_BK] - snap[E_FI] - snap[E_BK]), 64'd0);
      end
    end

    // Watchdog: timeout=8, core never answers.
    timeout_cycles_i = 16'd8;
    respond(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo8 start");
    respond(mk(E_RD, 2, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo8 rd");
    respond(mk(E_LD, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo8 ld");
    check("tmo8 core_start_seen", 64'(start_core_o), 64'd1);
    k = 0;
    while (!done_bm_o && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("tmo8 latency", 64'(k), 64'd8);
    z = mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1001, 2'd1);
    check_outs(z, "tmo8 end");

    // Watchdog disabled: core silent for 40 cycles, no timeout and no start re-issue.
    timeout_cycles_i = 16'd0;
    respond(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo0 start");
    respond(mk(E_RD, 2, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo0 rd");
    snap[E_CO] = n_start[E_CO];
    respond(mk(E_LD, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "tmo0 ld");
    repeat (40) @(negedge clk);
    check("tmo0 still_busy", 64'(done_bm_o), 64'd0);
    check("tmo0 core_starts", 64'(n_start[E_CO] - snap[E_CO]), 64'd1);

    // Asynchronous reset while in CORE.
    #2 rst = 1'b0;
    #1 check_reset_vals("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    tot = start_total();
    repeat (5) @(negedge clk);
    check("post_reset no_start", 64'(start_total() - tot), 64'd0);
    check("post_reset done", 64'(done_bm_o), 64'd0);

    // Abort together with done_load_i: abort wins.
    respond(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "abort start");
    respond(mk(E_RD, 3, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 2'd0), "abort rd");
    check("abort load_start", 64'(start_vec()), 64'(6'd1 << E_LD));
    done_load_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    done_load_i = 1'b0;
    tot = start_total();
    check_outs(mk(E_ST, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1001, 2'd2), "abort end");
    repeat (3) @(negedge clk);
    abort_i = 1'b0;
    check("abort held_code", 64'(err_code_o), 64'd2);
    check("abort no_core", 64'(start_total() - tot), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
